// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared types and helpers for the FIR sample-window manager:
//                state encoding, width helpers and the tap-count clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    // Control states of the window manager
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_WAIT_IN = 3'd2,
        ST_SEQ     = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Address width of the window RAM; never narrower than one bit
    function automatic int fir_tap_w(input int max_tap);
        return (max_tap > 1) ? $clog2(max_tap) : 1;
    endfunction

    // Width able to hold a tap count of 0..max_tap
    function automatic int fir_tn_w(input int max_tap);
        return $clog2(max_tap + 1);
    endfunction

    // Width able to hold a sample count of 0..max_data
    function automatic int fir_cnt_w(input int max_data);
        return $clog2(max_data + 1);
    endfunction

    // Zero taps behaves as one tap; oversized requests saturate at the RAM depth
    function automatic int fir_tn_clamp(input int tap_num, input int max_tap);
        if (tap_num < 1) begin
            return 1;
        end
        if (tap_num > max_tap) begin
            return max_tap;
        end
        return tap_num;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_ring_addr.sv
`default_nettype none
// ============================================================================
//  Module      : fir_ring_addr
//  Description : Circular-window address generator. Holds the write pointer
//                and the tap index k, and produces (wr_ptr - k) mod tn using
//                a one-bit-wider subtract with a +tn correction on underflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_ring_addr
    import fir_pkg::*;
#(
    parameter int TAP_W = 5,
    parameter int TN_W  = 6
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [TN_W-1:0]  tn_i,
    input  logic             start_seq_i,
    input  logic             step_i,
    input  logic             advance_i,
    output logic [TAP_W-1:0] rd_addr_o,
    output logic [TAP_W-1:0] k_o,
    output logic             k_last_o
);

    logic [TAP_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [TAP_W-1:0] k_q, k_d;
    logic [TN_W-1:0]  w_tn_last;
    logic             w_wr_last;
    logic [TAP_W:0]   w_diff;
    logic [TAP_W:0]   w_tn_ext;

    // Terminal-count detection and the wrapped read address
    always_comb begin
        w_tn_last = tn_i - TN_W'(1);
        k_last_o  = (TN_W'(k_q) == w_tn_last);
        w_wr_last = (TN_W'(wr_ptr_q) == w_tn_last);
        w_diff    = {1'b0, wr_ptr_q} - {1'b0, k_q};
        w_tn_ext  = (TAP_W+1)'(tn_i);
        rd_addr_o = w_diff[TAP_W] ? TAP_W'(w_diff + w_tn_ext) : w_diff[TAP_W-1:0];
        k_o       = k_q;
    end

    // Next-state: k wraps at tn-1, wr_ptr advances once per finished sequence
    always_comb begin
        k_d      = k_q;
        wr_ptr_d = wr_ptr_q;
        if (start_seq_i) begin
            k_d      = '0;
            wr_ptr_d = '0;
        end else begin
            if (step_i) begin
                k_d = k_last_o ? '0 : k_q + TAP_W'(1);
            end
            if (advance_i) begin
                wr_ptr_d = w_wr_last ? '0 : wr_ptr_q + TAP_W'(1);
            end
        end
    end

    // Pointer and index registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            k_q      <= '0;
            wr_ptr_q <= '0;
        end else begin
            k_q      <= k_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_data_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fir_data_buffer
//  Description : FIR sample-window manager between an AXI-Stream input and
//                the MAC datapath. Clears the window, stores each sample in a
//                circular BRAM and replays the last tn samples newest-first
//                with matching coefficient addresses.
//                Optional: define FIR_DBUF_TLAST_CHECK_EN to enable the
//                sticky err_tlast framing check.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_data_buffer
    import fir_pkg::*;
#(
    parameter int  DATA_WIDTH   = 32,
    parameter int  MAX_TAP_NUM  = 32,
    parameter int  MAX_DATA_NUM = 1024,
    localparam int TAP_W        = fir_tap_w(MAX_TAP_NUM),
    localparam int TN_W         = fir_tn_w(MAX_TAP_NUM),
    localparam int CNT_W        = fir_cnt_w(MAX_DATA_NUM),
    localparam int KEEP_W       = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    input  logic [TN_W-1:0]       tap_num,
    input  logic [CNT_W-1:0]      data_num,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_W-1:0]     s_tkeep,
    input  logic                  s_tlast,
    output logic                  bram_en,
    output logic [KEEP_W-1:0]     bram_we,
    output logic [TAP_W-1:0]      bram_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do,
    output logic                  tap_en,
    output logic [TAP_W-1:0]      tap_addr,
    output logic                  mac_valid,
    output logic [DATA_WIDTH-1:0] mac_data,
    output logic                  mac_first,
    output logic                  mac_last,
    output logic                  err_tlast
);

    state_t           state_q;
    logic [TN_W-1:0]  tn_q;
    logic [CNT_W-1:0] dn_q;
    logic [CNT_W-1:0] count_q;
    logic             mac_valid_q;
    logic             mac_first_q;
    logic             mac_last_q;
    logic [TAP_W-1:0] w_rd_addr;
    logic [TAP_W-1:0] w_k;
    logic             w_k_last;
    logic             w_start_seq;
    logic             w_step;
    logic             w_advance;

    assign w_start_seq = (state_q == ST_IDLE);
    assign w_step      = (state_q == ST_CLEAR) || (state_q == ST_SEQ);
    assign w_advance   = (state_q == ST_SEQ) && w_k_last;

    fir_ring_addr #(
        .TAP_W (TAP_W),
        .TN_W  (TN_W)
    ) u_ring (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .tn_i        (tn_q),
        .start_seq_i (w_start_seq),
        .step_i      (w_step),
        .advance_i   (w_advance),
        .rd_addr_o   (w_rd_addr),
        .k_o         (w_k),
        .k_last_o    (w_k_last)
    );

    // Control FSM with latched run parameters and registered MAC framing
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            tn_q        <= '0;
            dn_q        <= '0;
            count_q     <= '0;
            mac_valid_q <= 1'b0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
        end else begin
            mac_valid_q <= (state_q == ST_SEQ);
            mac_first_q <= (state_q == ST_SEQ) && (w_k == '0);
            mac_last_q  <= (state_q == ST_SEQ) && w_k_last;
            case (state_q)
                ST_IDLE: begin
                    if (ap_start) begin
                        tn_q    <= TN_W'(fir_tn_clamp(int'(tap_num), MAX_TAP_NUM));
                        dn_q    <= data_num;
                        count_q <= '0;
                        state_q <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (w_k_last) begin
                        state_q <= (dn_q == '0) ? ST_DONE : ST_WAIT_IN;
                    end
                end
                ST_WAIT_IN: begin
                    if (s_tvalid) begin
                        count_q <= count_q + CNT_W'(1);
                        state_q <= ST_SEQ;
                    end
                end
                ST_SEQ: begin
                    if (w_k_last) begin
                        state_q <= (count_q == dn_q) ? ST_DONE : ST_WAIT_IN;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FIR_DBUF_TLAST_CHECK_EN
    logic err_tlast_q;

    // Sticky framing check: tlast must appear exactly on the final sample
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_tlast_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && ap_start) begin
            err_tlast_q <= 1'b0;
        end else if ((state_q == ST_WAIT_IN) && s_tvalid) begin
            if (s_tlast != ((count_q + CNT_W'(1)) == dn_q)) begin
                err_tlast_q <= 1'b1;
            end
        end
    end

    assign err_tlast = err_tlast_q;
`else
    logic w_unused_tlast;
    assign w_unused_tlast = s_tlast;
    assign err_tlast      = 1'b0;
`endif

    // BRAM and coefficient port decode from the current state
    always_comb begin
        bram_en   = 1'b0;
        bram_we   = '0;
        bram_addr = '0;
        bram_di   = '0;
        tap_en    = 1'b0;
        tap_addr  = '0;
        case (state_q)
            ST_CLEAR: begin
                bram_en   = 1'b1;
                bram_we   = '1;
                bram_addr = w_k;
            end
            ST_WAIT_IN: begin
                // k is zero here, so the ring read address equals wr_ptr
                if (s_tvalid) begin
                    bram_en   = 1'b1;
                    bram_we   = s_tkeep;
                    bram_addr = w_rd_addr;
                    bram_di   = s_tdata;
                end
            end
            ST_SEQ: begin
                bram_en   = 1'b1;
                bram_addr = w_rd_addr;
                tap_en    = 1'b1;
                tap_addr  = w_k;
            end
            default: begin
            end
        endcase
    end

    assign s_tready  = (state_q == ST_WAIT_IN);
    assign ap_idle   = (state_q == ST_IDLE);
    assign ap_done   = (state_q == ST_DONE);
    assign mac_valid = mac_valid_q;
    assign mac_first = mac_first_q;
    assign mac_last  = mac_last_q;
    assign mac_data  = bram_do;

endmodule
`default_nettype wire
